// File: rtl/game_score_ctrl_pkg.sv
// Shared game definitions: FSM states, default game limits, display codes.
package game_score_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2,
    ST_QUIT = 2'd3
  } game_state_e;

  localparam int         MAX_SCORE_DEF = 32;
  localparam int         LIVES_DEF     = 10;
  localparam int         SCORE_W       = 6;
  localparam int         LEDR_W        = 10;
  localparam logic [3:0] HEX_BLANK     = 4'hF;
  localparam logic [3:0] MODE_MAX      = 4'd9;

  // Modes above 9 have no decimal digit, so they fall back to mode 0.
  function automatic logic [3:0] clamp_mode(input logic [3:0] m);
    return (m > MODE_MAX) ? 4'd0 : m;
  endfunction

endpackage

// File: rtl/game_score_ctrl_edge_detect.sv
// Rising-edge detector: one register stage, a held level yields one pulse.
module edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic sig,
  output logic pulse
);

  logic sig_d;
  logic sig_q;

  // Next value of the history stage is simply the current level.
  always_comb begin
    sig_d = sig;
  end

  // History register, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) sig_q <= 1'b0;
    else         sig_q <= sig_d;
  end

  assign pulse = sig & ~sig_q;

endmodule

// File: rtl/game_score_ctrl.sv
// Score / lives controller for the tile-matching game with registered
// display outputs (mode digit, score digits, lives bar on LEDR).
module game_score_ctrl
  import game_score_ctrl_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEF,
  parameter int LIVES     = LIVES_DEF,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic              match,
  input  logic              miss,
  input  logic              quit,
  input  logic [3:0]        mode,
  output logic              ingameOn,
  output logic              gameOver,
  output logic              userquit,
  output logic [3:0]        hex0hldr,
  output logic [3:0]        hex4hldr,
  output logic [3:0]        hex5hldr,
  output logic [LEDR_W-1:0] ledrhldr
);

  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(MAX_SCORE);
  localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(LIVES);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BLINK_DIV - 1);

  logic start_ev, match_ev, miss_ev, quit_ev;

  edge_detect u_start (.clk(CLOCK_50), .resetn(resetn), .sig(start), .pulse(start_ev));
  edge_detect u_match (.clk(CLOCK_50), .resetn(resetn), .sig(match), .pulse(match_ev));
  edge_detect u_miss  (.clk(CLOCK_50), .resetn(resetn), .sig(miss),  .pulse(miss_ev));
  edge_detect u_quit  (.clk(CLOCK_50), .resetn(resetn), .sig(quit),  .pulse(quit_ev));

  game_state_e        state_d, state_q;
  logic [SCORE_W-1:0] score_d, score_q;
  logic [LIVES_W-1:0] lives_d, lives_q;
  logic [3:0]         mode_d, mode_q;
  logic               win_d, win_q;
  logic [CNT_W-1:0]   blink_cnt_d, blink_cnt_q;
  logic               blink_on_d, blink_on_q;

  logic              ingame_d, ingame_q;
  logic              over_d, over_q;
  logic              quit_d, quit_q;
  logic [3:0]        hex0_d, hex0_q;
  logic [3:0]        hex4_d, hex4_q;
  logic [3:0]        hex5_d, hex5_q;
  logic [LEDR_W-1:0] ledr_d, ledr_q;
  logic [LEDR_W-1:0] lives_bar;

  // Game FSM and counters: quit wins over everything except while already quit.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    mode_d      = mode_q;
    win_d       = win_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (quit_ev && state_q != ST_QUIT) begin
      state_d = ST_QUIT;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER, ST_QUIT: begin
          if (start_ev) begin
            state_d = ST_PLAY;
            score_d = '0;
            lives_d = LIVES_FULL;
            mode_d  = clamp_mode(mode);
            win_d   = 1'b0;
          end
        end
        ST_PLAY: begin
          if (match_ev && score_q != SCORE_WIN) score_d = score_q + SCORE_W'(1);
          if (miss_ev && lives_q != '0)         lives_d = lives_q - LIVES_W'(1);
          if (score_d == SCORE_WIN) begin
            state_d = ST_OVER;
            win_d   = 1'b1;
          end else if (lives_d == '0) begin
            state_d = ST_OVER;
            win_d   = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_q == ST_OVER && state_d == ST_OVER) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end else begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b0;
    end
  end

  // Display values derived from next-state so outputs change with the state.
  always_comb begin
    lives_bar = '0;
    for (int i = 0; i < LEDR_W; i++) lives_bar[i] = (i < int'(lives_d));
    ingame_d = (state_d == ST_PLAY);
    over_d   = (state_d == ST_OVER);
    quit_d   = (state_d == ST_QUIT);
    hex0_d   = mode_d;
    hex4_d   = score_d[3:0];
    hex5_d   = {2'b00, score_d[5:4]};
    ledr_d   = lives_bar;
    case (state_d)
      ST_QUIT: begin
        hex0_d = HEX_BLANK;
        hex4_d = HEX_BLANK;
        hex5_d = HEX_BLANK;
        ledr_d = '0;
      end
      ST_OVER: ledr_d = (win_d || blink_on_d) ? '1 : '0;
      default: ledr_d = lives_bar;
    endcase
  end

  // All state and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      lives_q     <= LIVES_FULL;
      mode_q      <= '0;
      win_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      ingame_q    <= 1'b0;
      over_q      <= 1'b0;
      quit_q      <= 1'b0;
      hex0_q      <= '0;
      hex4_q      <= '0;
      hex5_q      <= '0;
      ledr_q      <= '1;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      mode_q      <= mode_d;
      win_q       <= win_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      ingame_q    <= ingame_d;
      over_q      <= over_d;
      quit_q      <= quit_d;
      hex0_q      <= hex0_d;
      hex4_q      <= hex4_d;
      hex5_q      <= hex5_d;
      ledr_q      <= ledr_d;
    end
  end

  assign ingameOn = ingame_q;
  assign gameOver = over_q;
  assign userquit = quit_q;
  assign hex0hldr = hex0_q;
  assign hex4hldr = hex4_q;
  assign hex5hldr = hex5_q;
  assign ledrhldr = ledr_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Self-checking bench for game_score_ctrl: directed scenarios plus random
// stimulus compared every cycle against a behavioural game model.
module tb_game_score_ctrl;

  localparam int BLINK = 4;
  localparam int MAXS  = 32;
  localparam int NLIV  = 10;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       start    = 1'b0;
  logic       match    = 1'b0;
  logic       miss     = 1'b0;
  logic       quit     = 1'b0;
  logic [3:0] mode     = 4'd0;
  logic       ingameOn, gameOver, userquit;
  logic [3:0] hex0hldr, hex4hldr, hex5hldr;
  logic [9:0] ledrhldr;

  game_score_ctrl #(.MAX_SCORE(MAXS), .LIVES(NLIV), .BLINK_DIV(BLINK)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .match(match),
    .miss(miss), .quit(quit), .mode(mode), .ingameOn(ingameOn),
    .gameOver(gameOver), .userquit(userquit), .hex0hldr(hex0hldr),
    .hex4hldr(hex4hldr), .hex5hldr(hex5hldr), .ledrhldr(ledrhldr)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int vectorCount = 0;
  int missCount   = 0;

  // Model of the game in plain terms: a phase name, a score and a life count.
  typedef enum {M_IDLE, M_PLAY, M_OVER, M_QUIT, M_RESET} phase_e;
  phase_e mPhase = M_RESET;
  int     mScore = 0, mLives = NLIV, mMode = 0, mOverCycles = 0;
  bit     mWin = 0;
  bit     pStart = 0, pMatch = 0, pMiss = 0, pQuit = 0;
  logic [3:0] curMode = 4'd0;

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the given input levels.
  task automatic modelStep(input bit s, m, mi, q, input logic [3:0] md, input bit rn);
    bit evS, evM, evMi, evQ, wasOver;
    if (!rn) begin
      mPhase = M_RESET; mScore = 0; mLives = NLIV; mMode = 0; mWin = 0; mOverCycles = 0;
      pStart = 0; pMatch = 0; pMiss = 0; pQuit = 0;
      return;
    end
    evS = s && !pStart; evM = m && !pMatch; evMi = mi && !pMiss; evQ = q && !pQuit;
    pStart = s; pMatch = m; pMiss = mi; pQuit = q;
    if (mPhase == M_RESET) mPhase = M_IDLE;
    wasOver = (mPhase == M_OVER);
    if (evQ && mPhase != M_QUIT) begin
      mPhase = M_QUIT;
    end else if (mPhase == M_PLAY) begin
      if (evM)  mScore = (mScore + 1 > MAXS) ? MAXS : mScore + 1;
      if (evMi) mLives = (mLives == 0) ? 0 : mLives - 1;
      if (mScore == MAXS)  begin mPhase = M_OVER; mWin = 1; end
      else if (mLives == 0) begin mPhase = M_OVER; mWin = 0; end
    end else if (evS) begin
      mPhase = M_PLAY; mScore = 0; mLives = NLIV; mWin = 0;
      mMode = (md > 9) ? 0 : int'(md);
    end
    if (mPhase == M_OVER && wasOver) mOverCycles++;
    else mOverCycles = 0;
  endtask

  // Compare every DUT output against what the model says should be shown.
  task automatic checkAll();
    logic [9:0] eLedr;
    if (mPhase == M_RESET) begin
      checkOutput("rst_ingame", ingameOn, 0); checkOutput("rst_over", gameOver, 0);
      checkOutput("rst_quit", userquit, 0);   checkOutput("rst_hex0", hex0hldr, 0);
      checkOutput("rst_hex4", hex4hldr, 0);   checkOutput("rst_hex5", hex5hldr, 0);
      checkOutput("rst_ledr", ledrhldr, 10'h3FF);
      return;
    end
    checkOutput("ingameOn", ingameOn, mPhase == M_PLAY);
    checkOutput("gameOver", gameOver, mPhase == M_OVER);
    checkOutput("userquit", userquit, mPhase == M_QUIT);
    if (mPhase == M_QUIT) begin
      checkOutput("hex0", hex0hldr, 4'hF); checkOutput("hex4", hex4hldr, 4'hF);
      checkOutput("hex5", hex5hldr, 4'hF); checkOutput("ledr", ledrhldr, 0);
      return;
    end
    checkOutput("hex0", hex0hldr, mMode);
    checkOutput("hex4", hex4hldr, mScore % 16);
    checkOutput("hex5", hex5hldr, mScore / 16);
    if (mPhase == M_OVER)
      eLedr = (mWin || ((mOverCycles / BLINK) % 2 == 1)) ? 10'h3FF : 10'h000;
    else
      eLedr = 10'((1 << mLives) - 1);
    checkOutput("ledr", ledrhldr, eLedr);
  endtask

  // Drive one cycle of inputs, clock it, then check outputs just after the edge.
  task automatic applyStimulus(input bit s, m, mi, q, input logic [3:0] md, input bit rn);
    start = s; match = m; miss = mi; quit = q; mode = md; resetn = rn;
    @(posedge CLOCK_50);
    modelStep(s, m, mi, q, md, rn);
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, curMode, 1);
  endtask

  task automatic resetCycle();
    applyStimulus(0, 0, 0, 0, curMode, 0);
  endtask

  task automatic pulseStart(input logic [3:0] md);
    curMode = md;
    applyStimulus(1, 0, 0, 0, md, 1);
    applyStimulus(0, 0, 0, 0, md, 1);
  endtask

  task automatic pulseMatch();
    applyStimulus(0, 1, 0, 0, curMode, 1);
    applyStimulus(0, 0, 0, 0, curMode, 1);
  endtask

  task automatic pulseMiss();
    applyStimulus(0, 0, 1, 0, curMode, 1);
    applyStimulus(0, 0, 0, 0, curMode, 1);
  endtask

  initial begin
    resetCycle();
    resetCycle();

    // Start then three matches.
    pulseStart(4'd3);
    repeat (3) pulseMatch();
    checkOutput("m3_ingame", ingameOn, 1);
    checkOutput("m3_hex5", hex5hldr, 0);
    checkOutput("m3_hex4", hex4hldr, 3);
    checkOutput("m3_ledr", ledrhldr, 10'h3FF);

    // Winning game and saturation.
    resetCycle();
    pulseStart(4'd7);
    repeat (32) pulseMatch();
    checkOutput("win_hex5", hex5hldr, 2);
    checkOutput("win_hex4", hex4hldr, 0);
    checkOutput("win_over", gameOver, 1);
    checkOutput("win_ledr", ledrhldr, 10'h3FF);
    idleCycles(10);
    checkOutput("win_ledr_steady", ledrhldr, 10'h3FF);
    pulseMatch();
    checkOutput("win_extra_hex4", hex4hldr, 0);
    checkOutput("win_extra_hex5", hex5hldr, 2);

    // Losing game: lives bar shrinks then blinks.
    pulseStart(4'd1);
    for (int k = 1; k <= 10; k++) begin
      pulseMiss();
      checkOutput("lose_ledr_step", ledrhldr, 10'h3FF >> k);
    end
    checkOutput("lose_over", gameOver, 1);
    idleCycles(20);

    // Simultaneous match, miss and quit at score 5.
    pulseStart(4'd2);
    repeat (5) pulseMatch();
    applyStimulus(0, 1, 1, 1, curMode, 1);
    checkOutput("q_userquit", userquit, 1);
    checkOutput("q_hex0", hex0hldr, 4'hF);
    checkOutput("q_hex4", hex4hldr, 4'hF);
    checkOutput("q_hex5", hex5hldr, 4'hF);
    checkOutput("q_ledr", ledrhldr, 0);
    applyStimulus(0, 0, 0, 0, curMode, 1);
    pulseStart(4'd2);
    checkOutput("q_restart_ingame", ingameOn, 1);
    checkOutput("q_restart_hex4", hex4hldr, 0);

    // Held start with an out-of-range mode, then a held match.
    resetCycle();
    curMode = 4'hC;
    repeat (100) applyStimulus(1, 0, 0, 0, 4'hC, 1);
    checkOutput("hold_ingame", ingameOn, 1);
    checkOutput("hold_hex0", hex0hldr, 0);
    repeat (20) applyStimulus(1, 1, 0, 0, 4'hC, 1);
    checkOutput("hold_hex4", hex4hldr, 1);
    idleCycles(2);

    // Reset in the middle of a game at score 7.
    resetCycle();
    pulseStart(4'd5);
    repeat (7) pulseMatch();
    checkOutput("mid_hex4", hex4hldr, 7);
    resetCycle();
    checkOutput("mid_ingame", ingameOn, 0);
    checkOutput("mid_over", gameOver, 0);
    checkOutput("mid_quit", userquit, 0);
    checkOutput("mid_hex4_rst", hex4hldr, 0);
    idleCycles(1);
    checkOutput("mid_idle_ledr", ledrhldr, 10'h3FF);

    // Random play against the model.
    for (int i = 0; i < 1500; i++) begin
      bit s, m, mi, q, rn;
      logic [3:0] md;
      s  = ($urandom_range(0, 11) == 0);
      m  = ($urandom_range(0, 2) == 0);
      mi = ($urandom_range(0, 3) == 0);
      q  = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 149) != 0);
      md = 4'($urandom_range(0, 15));
      curMode = md;
      applyStimulus(s, m, mi, q, md, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/game_score_ctrl.md
GAME_SCORE_CTRL -- requirements
Module: game_score_ctrl

Interface
REQ-001 SHALL have parameter MAX_SCORE, default 32, meaning the score at which the game is won (6-bit score range).
REQ-002 SHALL have parameter LIVES, default 10, meaning the misses allowed; one LEDR per life.
REQ-003 SHALL have parameter BLINK_DIV, default 25_000_000, meaning the CLOCK_50 cycles per LEDR blink half-period after a loss.
REQ-004 SHALL have port CLOCK_50  input  1  system clock; the only clock.
REQ-005 SHALL have port resetn  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port start  input  1  level, active-high, already synchronized.
REQ-007 SHALL have port match  input  1  level, active-high, tile pair matched.
REQ-008 SHALL have port miss  input  1  level, active-high, tile pair mismatched.
REQ-009 SHALL have port quit  input  1  level, active-high, user abort.
REQ-010 SHALL have port mode  input  4  game mode selector, 0-9.
REQ-011 SHALL have port ingameOn  output  1  high in PLAY.
REQ-012 SHALL have port gameOver  output  1  high in OVER.
REQ-013 SHALL have port userquit  output  1  high in QUIT.
REQ-014 SHALL have port hex0hldr  output  4  latched mode digit.
REQ-015 SHALL have port hex4hldr  output  4  score[3:0].
REQ-016 SHALL have port hex5hldr  output  4  {2'b00, score[5:4]}.
REQ-017 SHALL have port ledrhldr  output  10  lives bar / end pattern.

Function
REQ-018 SHALL detect rising edges of start, match, miss and quit with one register stage each; a held level SHALL act as one event.
REQ-019 SHALL implement the states IDLE, PLAY, OVER and QUIT.
REQ-020 SHALL register every output, with a change visible the cycle after the clock edge that sees the event edge.
REQ-021 In IDLE, SHALL on start enter PLAY, set score=0 and lives=LIVES, and latch mode, substituting 0 for any value above 9.
REQ-022 In PLAY, SHALL on match increment score, saturating at MAX_SCORE, and on miss decrement lives, saturating at 0.
REQ-023 In PLAY, SHALL enter OVER with win=1 when score reaches MAX_SCORE, or with win=0 when lives reaches 0.
REQ-024 When match and miss occur in the same cycle, SHALL apply both; if both end conditions are then met, win SHALL take precedence.
REQ-025 When quit occurs, SHALL give it priority over match, miss and start in every state except QUIT, and enter QUIT without altering score.
REQ-026 SHALL ignore match and miss in IDLE, OVER and QUIT.
REQ-027 In OVER or QUIT, SHALL on start enter PLAY with a fresh score, lives and latched mode.
REQ-028 In IDLE and PLAY, SHALL drive ledrhldr bit i high when i < lives.
REQ-029 In OVER with win=1, SHALL drive ledrhldr = 10'h3FF steadily.
REQ-030 In OVER with win=0, SHALL toggle ledrhldr between 10'h3FF and 0 every BLINK_DIV cycles, starting at 0; the blink counter SHALL clear on entry to OVER.
REQ-031 In QUIT, SHALL drive hex0hldr, hex4hldr and hex5hldr = 4'hF (blank) and ledrhldr = 0.
REQ-032 Outside QUIT, SHALL drive hex4hldr and hex5hldr from score so that the 0..32 binary encoding matches the downstream decimal converter.

Reset
REQ-033 SHALL, with resetn low at a clock edge, set state to IDLE, score to 0, lives to LIVES, mode to 0, win to 0, the blink counter to 0 and the edge registers to 0.
REQ-034 SHALL, while in reset, drive ingameOn/gameOver/userquit = 0, hex0hldr/hex4hldr/hex5hldr = 0 and ledrhldr = 10'h3FF.
REQ-035 SHALL, on reset mid-game, abandon the game with no event recorded.

Structure
REQ-036 SHALL take the state encoding, MAX_SCORE, LIVES and the blank code 4'hF from the shared game package.
REQ-037 SHALL use one sub-module, edge_detect, instantiated four times.

Verification
REQ-038 Reset, start, then 3 match pulses -> ingameOn=1, hex5hldr=0, hex4hldr=3, ledrhldr=10'h3FF.
REQ-039 32 match pulses from a fresh game -> hex5hldr=2, hex4hldr=0, gameOver=1, ledrhldr steady 10'h3FF; a 33rd match -> no change.
REQ-040 10 miss pulses -> ledrhldr steps 3FF, 1FF ... 001, 000; gameOver=1; with BLINK_DIV=4, LEDR toggles every 4 cycles.
REQ-041 match, miss and quit in the same cycle during PLAY at score 5 -> QUIT, userquit=1, all hex outputs=F, ledrhldr=0; start -> PLAY, score 0.
REQ-042 start held high for 100 cycles with mode=4'hC -> a single PLAY entry, hex0hldr=0; match held high -> score increments once.
REQ-043 resetn low mid-PLAY at score 7 -> next cycle IDLE, all flags 0, hex4hldr=0.
